// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and the init-pattern helper for the multi-port
//               register file (init mode, FSM states, init value function).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        INIT_ZERO      = 1'b0,
        INIT_INDEX_BCD = 1'b1
    } init_mode_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } rf_state_e;

    // Init value for entry idx: zero, or two-digit BCD of idx (NREGS <= 100).
    // The result is masked to xlen bits; registers wider than 64 bits are not
    // supported by this helper.
    function automatic logic [63:0] init_value(input int unsigned idx,
                                               input init_mode_e  mode,
                                               input int unsigned xlen);
        logic [63:0] v;
        v = '0;
        if (mode == INIT_INDEX_BCD) begin
            v[7:4] = 4'((idx / 10) % 10);
            v[3:0] = 4'(idx % 10);
        end
        if (xlen < 64) begin
            v = v & ((64'd1 << xlen) - 64'd1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_init_seq
// Description : Post-reset initialisation walk. Writes entries 1..NREGS-1
//               with their init pattern, one per edge, then raises ready.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 32,
    parameter init_mode_e  INIT_MODE = INIT_INDEX_BCD,
    localparam int         AW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            init_we,
    output logic [AW-1:0]   init_addr,
    output logic [XLEN-1:0] init_data,
    output logic            ready
);

    // One bit wider than an address so the counter can never alias entry 0.
    localparam logic [AW:0] C_LAST_IDX = (AW+1)'(NREGS - 1);

    rf_state_e   r_state;
    logic [AW:0] r_init_idx;

    // State machine and walk counter; reset restarts the walk from entry 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_init_idx <= (AW+1)'(1);
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_INIT;
                ST_INIT: begin
                    if (r_init_idx == C_LAST_IDX) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_init_idx <= r_init_idx + (AW+1)'(1);
                    end
                end
                ST_RUN:   r_state <= ST_RUN;
                default:  r_state <= ST_RESET;
            endcase
        end
    end

    assign init_we   = (r_state == ST_INIT);
    assign init_addr = r_init_idx[AW-1:0];
    assign init_data = XLEN'(init_value(int'(r_init_idx), INIT_MODE, XLEN));
    assign ready     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Parametrised multi-port integer register file with x0
//               hardwired to zero, post-reset init walk, ready flag and
//               optional same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 32,
    parameter int          NRD       = 2,
    parameter int          NWR       = 1,
    parameter init_mode_e  INIT_MODE = INIT_INDEX_BCD,
    parameter bit          BYPASS    = 1'b1,
    localparam int         AW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                ready
);

    logic            w_init_we;
    logic [AW-1:0]   w_init_addr;
    logic [XLEN-1:0] w_init_data;
    logic            w_ready;

    // Entry 0 has no storage.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    regfile_init_seq #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .init_data (w_init_data),
        .ready     (w_ready)
    );

    // Storage update: init walk has priority; user writes only when ready.
    // Ports are visited in ascending order so port 1 wins on a conflict.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_regs[w_init_addr] <= w_init_data;
        end else if (w_ready) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_val;

        assign w_ra = rd_addr[p*AW +: AW];

        // Combinational read with optional bypass; zero until ready or for x0.
        always_comb begin
            w_val = '0;
            if (w_ready && (w_ra != '0)) begin
                w_val = r_regs[w_ra];
                if (BYPASS) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == w_ra)) begin
                            w_val = wr_data[w*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        assign rd_data[p*XLEN +: XLEN] = w_val;
    end

    assign ready = w_ready;

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the RISC-V core: generalises the single-write, two-read 32×32 file to configurable width, depth, read-port and write-port counts. Adds a sequenced post-reset initialisation walk with a `ready` flag, configurable init pattern, and optional write-to-read bypass. Sits between decode (read addresses) and writeback (write ports). With `NWR=2` it also serves a dual-issue writeback.

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: number of architectural registers; power of two, ≥4; `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, 1..4.
- `NWR`, 1: number of write ports, 1..2.
- `INIT_MODE`, `INIT_INDEX_BCD`: `INIT_ZERO` (all entries 0) or `INIT_INDEX_BCD` (entry i = two-digit BCD of i, zero-extended; e.g. 12 → 32'h12).
- `BYPASS`, 1: 1 = a same-cycle write is visible on the read port; 0 = read returns the stored value.

Ports:
- `clk`, in, 1: single clock. All state updates occur on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rd_addr`, in, `NRD×AW`: read addresses, packed; port p = bits `[p*AW +: AW]`.
- `rd_data`, out, `NRD×XLEN`: read data, packed likewise.
- `wr_en`, in, `NWR`: per-port write enable.
- `wr_addr`, in, `NWR×AW`: write addresses.
- `wr_data`, in, `NWR×XLEN`: write data.
- `ready`, out, 1: 1 when the init walk is complete and the file accepts writes.

## Operation
- Register 0 is hardwired: it always reads 0, writes to it are discarded, and it has no storage.
- FSM states, in `regfile_pkg`:
  - `ST_RESET`: entered whenever `reset`=1, from any state. `init_idx` is set to 1.
  - `ST_INIT`: entered on the first edge with `reset`=0. On each edge, entry `init_idx` receives its init value and `init_idx` increments. After the edge that writes entry `NREGS-1`, the state moves to `ST_RUN`.
  - `ST_RUN`: normal operation until `reset`.
- Reset or init mid-operation: asserting `reset` during `ST_INIT` or `ST_RUN` restarts the walk from entry 1. Stored contents are not cleared instantaneously; they are overwritten by the walk.
- Writes in `ST_RESET` and `ST_INIT` are dropped silently. Upstream must wait for `ready`.
- Reads are combinational (asynchronous). `rd_data` is forced to 0 on all ports while `ready`=0.
- Write-port conflict: if `NWR`=2 and both ports write the same nonzero address in one cycle, port 1 wins.
- Bypass (`BYPASS`=1, `ST_RUN` only): if a read address equals an enabled nonzero write address, `rd_data` = `wr_data` of that port. The port-1-wins rule applies to bypass selection as well.
- No arithmetic is performed. Init value for `INIT_INDEX_BCD`: `{i/10, i%10}` as 4-bit nibbles, valid for `NREGS` ≤ 100.

## Timing
- Reset values: `ready`=0; `rd_data`=0 on all ports.
- Init latency: `ready` rises `NREGS-1` rising edges after the first edge with `reset`=0 (31 edges for the default). It remains 1 until `reset`.
- Write latency: data is stored at the rising edge where `wr_en`=1. Without bypass it is readable from the following cycle.
- With bypass: visible combinationally in the same cycle, meaning zero-cycle latency.
- Read-during-write with `BYPASS`=0: returns the old value.
- Address wrap-around does not occur: `init_idx` is `AW+1` bits and stops at `NREGS-1`.

## Structure
- `regfile_pkg` holds:
  - the `init_mode_e` enum (`INIT_ZERO`, `INIT_INDEX_BCD`);
  - the `rf_state_e` enum (`ST_RESET`, `ST_INIT`, `ST_RUN`);
  - the function `init_value(idx, mode, xlen)`.
- Sub-module `regfile_init_seq` contains the FSM and `init_idx` counter. It outputs `init_we`, `init_addr`, `init_data` and `ready`.
- The top level muxes `init_we`/`init_addr`/`init_data` with the write ports, and contains the storage array, the read muxes and the bypass logic.

## Test plan
- Init walk: hold `reset` 2 cycles, release, count edges. Required: `ready`=0 for 31 edges, then 1; reading x10 returns 32'h10 and x31 returns 32'h31 (`INIT_INDEX_BCD`); with `INIT_ZERO`, x31 returns 0.
- x0: write 32'hDEADBEEF to x0, then read. Required: 0 on every port, both same cycle and next cycle.
- Bypass: with `BYPASS`=1, write 32'hA5A5 to x5 while `rd_addr[0]`=5. Required: `rd_data[0]`=32'hA5A5 in the same cycle. With `BYPASS`=0: old value 32'h5 that cycle, 32'hA5A5 the next.
- Dual-write conflict (`NWR`=2): port 0 writes x7=1 and port 1 writes x7=2 in the same cycle. Required: x7 reads 2. Different addresses: both are stored.
- Write during init: assert `wr_en` with x3=32'hFF at init edge 5. Required: the write is dropped, and x3=32'h3 after `ready`.
- Mid-run reset: in `ST_RUN`, write x4=32'h99, then pulse `reset` for 1 cycle. Required: `ready` drops the same edge, the walk restarts, and after 31 edges x4 reads 32'h4.
